led_scan_scheduler: RTL and testbench

//  Time-multiplexing scheduler for the 8-digit seven-segment display of the clip recorder.
//  - Scans one digit per slot, with a blanking gap between digits to prevent ghosting.
//  - Holds a shadow/active pair of digit banks; the host loads the shadow bank and commits it
//    at a frame boundary.
//  - Overlays record/play status on digits 7/6, sitting between the record/play control logic
//    and the board anode/cathode pins.

---
 rtl/led_scan_scheduler.sv | 138 +++++++++++++
 tb/tb_led_scan_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_scheduler.sv
// led_scan_scheduler
//   Time-multiplexed driver for an 8-digit seven-segment display. Each digit gets
//   one slot of TICK_DIV clocks; the first BLANK_CYCLES clocks of a slot keep every
//   anode off so the previous digit's segments cannot ghost into the next digit.
//   The host writes a shadow bank and commits it. The active bank is updated only
//   at a frame boundary, where the scan wraps from digit 7 back to digit 0.
//   Record/play status is overlaid live on digits 7 and 6.
// Ports
//   clock, reset          : system clock; synchronous active-high reset
//   wr_valid/wr_ready     : shadow write handshake (wr_digit, wr_value)
//   wr_commit             : request a shadow->active copy at the next frame boundary
//   record, play          : overlay enables; record wins when both are high
//   recordNum/clipPlayNum : clip number shown on digit 6 (0=clip1, 1=clip2)
//   anode                 : active-low digit enables; anode[i] selects digit i
//   cathode               : active-low segments {a,b,c,d,e,f,g}
//   frame_start           : one-cycle pulse as each new digit-0 slot begins
module led_scan_scheduler #(
    parameter int TICK_DIV     = 12500,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_digit,
    input  logic [4:0] wr_value,
    input  logic       wr_commit,
    input  logic       record,
    input  logic       play,
    input  logic       recordNum,
    input  logic       clipPlayNum,
    output logic [7:0] anode,
    output logic [6:0] cathode,
    output logic       frame_start
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [6:0] SEG_R     = 7'b1111010;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_ONE   = 7'b1001111;
    localparam logic [6:0] SEG_TWO   = 7'b0010010;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   slot_cnt;
    logic [2:0]      idx;
    logic            commit_pending;
    logic [7:0][4:0] shadow, active;

    logic            slot_wrap, frame_wrap;
    logic [7:0]      anode_nx;
    logic [6:0]      cathode_nx;

    function automatic logic [6:0] glyph(input logic [4:0] v);
        logic [6:0] s;
        if (v[4]) s = SEG_BLANK;
        else begin
            case (v[3:0])
                4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
                4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
                4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
                4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
                4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
                4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
                4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
                4'hE: s = 7'b0110000;  default: s = 7'b0111000;
            endcase
        end
        return s;
    endfunction

    assign slot_wrap  = (slot_cnt == CW'(TICK_DIV - 1));
    assign frame_wrap = slot_wrap && (idx == 3'd7);
    // Ready simply mirrors "no commit outstanding": it drops the cycle after a
    // commit is accepted and returns the cycle after the copy clears it.
    assign wr_ready   = !commit_pending;

    always_comb begin
        state_nx   = state;
        anode_nx   = 8'hFF;
        cathode_nx = SEG_BLANK;

        if (slot_wrap)
            state_nx = BLANK;
        else if (slot_cnt == CW'(BLANK_CYCLES - 1))
            state_nx = SHOW;

        if (state == SHOW) begin
            anode_nx   = ~(8'd1 << idx);
            cathode_nx = glyph(active[idx]);
            // Overlay inputs are used as sampled this cycle, never latched.
            if (record) begin
                if (idx == 3'd7)      cathode_nx = SEG_R;
                else if (idx == 3'd6) cathode_nx = recordNum ? SEG_TWO : SEG_ONE;
            end else if (play) begin
                if (idx == 3'd7)      cathode_nx = SEG_P;
                else if (idx == 3'd6) cathode_nx = clipPlayNum ? SEG_TWO : SEG_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= BLANK;
            slot_cnt       <= '0;
            idx            <= '0;
            commit_pending <= 1'b0;
            shadow         <= {8{5'h10}};
            active         <= {8{5'h10}};
            anode          <= 8'hFF;
            cathode        <= SEG_BLANK;
            frame_start    <= 1'b0;
        end else begin
            state       <= state_nx;
            slot_cnt    <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                idx <= idx + 3'd1;
            anode       <= anode_nx;
            cathode     <= cathode_nx;
            frame_start <= frame_wrap;

            if (wr_valid && wr_ready)
                shadow[wr_digit] <= wr_value;
            if (wr_commit && wr_ready)
                commit_pending <= 1'b1;
            // Pending is tested before this edge updates it. A commit that is
            // accepted on the wrap edge therefore waits a full frame.
            if (frame_wrap && commit_pending) begin
                active         <= shadow;
                commit_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_scheduler.sv
module tb_led_scan_scheduler;

    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FRAME = 8 * TD;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0, wr_commit = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_digit = '0;
    logic [4:0] wr_value = '0;
    logic       record = 1'b0, play = 1'b0, recordNum = 1'b0, clipPlayNum = 1'b0;
    logic [7:0] anode;
    logic [6:0] cathode;
    logic       frame_start;

    int tests = 0;
    int fails = 0;

    // Reference model: position in time since reset plus two banks and a pending flag.
    int         n;
    logic [4:0] msh [8];
    logic [4:0] mac [8];
    bit         mpend;
    logic [7:0] ea;
    logic [6:0] ec;
    logic       efs, erdy;

    led_scan_scheduler #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_digit(wr_digit), .wr_value(wr_value),
        .wr_commit(wr_commit), .record(record), .play(play),
        .recordNum(recordNum), .clipPlayNum(clipPlayNum),
        .anode(anode), .cathode(cathode), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] ref_glyph(input logic [4:0] v);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
              7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return v[4] ? 7'h7F : t[v[3:0]];
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        if (record && d == 7) return 7'b1111010;
        if (record && d == 6) return recordNum ? 7'b0010010 : 7'b1001111;
        if (play && d == 7)   return 7'b0011000;
        if (play && d == 6)   return clipPlayNum ? 7'b0010010 : 7'b1001111;
        return ref_glyph(mac[d]);
    endfunction

    task automatic model_edge();
        if (reset) begin
            n = 0;
            mpend = 0;
            for (int i = 0; i < 8; i++) begin msh[i] = 5'h10; mac[i] = 5'h10; end
            ea = 8'hFF; ec = 7'h7F; efs = 1'b0;
        end else begin
            int slot, d;
            slot = n % TD;
            d    = (n / TD) % 8;
            if (slot >= BC) begin
                ea = ~(8'd1 << d);
                ec = ref_seg(d);
            end else begin
                ea = 8'hFF; ec = 7'h7F;
            end
            efs = ((n + 1) % FRAME == 0);
            if (mpend) begin
                if (n % FRAME == FRAME - 1) begin
                    for (int i = 0; i < 8; i++) mac[i] = msh[i];
                    mpend = 0;
                end
            end else begin
                if (wr_valid) msh[wr_digit] = wr_value;
                if (wr_commit) mpend = 1;
            end
            n++;
        end
        erdy = !mpend;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        tests += 4;
        assert (anode === ea) else begin
            fails++; $error("FAIL anode n=%0d got=%h exp=%h", n, anode, ea);
        end
        assert (cathode === ec) else begin
            fails++; $error("FAIL cathode n=%0d got=%b exp=%b", n, cathode, ec);
        end
        assert (frame_start === efs) else begin
            fails++; $error("FAIL frame_start n=%0d got=%b exp=%b", n, frame_start, efs);
        end
        assert (wr_ready === erdy) else begin
            fails++; $error("FAIL wr_ready n=%0d got=%b exp=%b", n, wr_ready, erdy);
        end
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Run until digit d is lit, then compare its segments against a fixed glyph.
    task automatic check_digit(input int d, input logic [6:0] exp);
        logic [7:0] tgt;
        bit found;
        tgt = ~(8'd1 << d);
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (anode === tgt) found = 1;
        end
        tests++;
        assert (found && cathode === exp) else begin
            fails++;
            $error("FAIL digit%0d found=%0b got=%b exp=%b", d, found, cathode, exp);
        end
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2 * FRAME + 4 && !ok; i++) begin
            tick();
            if (wr_ready === 1'b1) ok = 1;
        end
        tests++;
        assert (ok) else begin fails++; $error("FAIL wait_ready got=timeout exp=ready"); end
    endtask

    task automatic write(input logic [2:0] d, input logic [4:0] v, input logic c);
        wr_valid = 1'b1; wr_digit = d; wr_value = v; wr_commit = c;
        tick();
        wr_valid = 1'b0; wr_commit = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        ticks(2);
        tests++;
        assert (anode === 8'hFF && cathode === 7'h7F && frame_start === 1'b0 && wr_ready === 1'b1)
        else begin
            fails++;
            $error("FAIL reset got=%h/%h/%b/%b exp=ff/7f/0/1", anode, cathode, frame_start, wr_ready);
        end
        reset = 1'b0;

        // 1: idle scan, all digits blank
        ticks(64);

        // 2: write and commit two digits
        write(3'd0, 5'h03, 1'b0);
        write(3'd1, 5'h0A, 1'b1);
        tick();
        tests++;
        assert (wr_ready === 1'b0) else begin fails++; $error("FAIL ready_low got=%b exp=0", wr_ready); end
        wait_ready();
        check_digit(0, 7'b0000110);
        check_digit(1, 7'b0001000);
        check_digit(2, 7'h7F);

        // 3: uncommitted shadow write stays invisible
        write(3'd3, 5'h05, 1'b0);
        ticks(3 * FRAME);
        check_digit(3, 7'h7F);
        write(3'd7, 5'h1F, 1'b1);
        wait_ready();
        check_digit(3, 7'b0100100);

        // 4: overlays
        record = 1'b1; recordNum = 1'b1; play = 1'b1; clipPlayNum = 1'b0;
        check_digit(7, 7'b1111010);
        check_digit(6, 7'b0010010);
        record = 1'b0;
        check_digit(7, 7'b0011000);
        check_digit(6, 7'b1001111);
        clipPlayNum = 1'b1;
        check_digit(6, 7'b0010010);
        play = 1'b0;
        check_digit(7, 7'h7F);

        // 5: write while not ready is dropped
        write(3'd5, 5'h10, 1'b1);
        write(3'd2, 5'h07, 1'b0);
        wait_ready();
        check_digit(2, 7'h7F);

        // 6: reset while a commit is pending
        write(3'd4, 5'h08, 1'b1);
        ticks(3);
        reset = 1'b1;
        tick();
        tests++;
        assert (anode === 8'hFF && cathode === 7'h7F && wr_ready === 1'b1) else begin
            fails++; $error("FAIL midreset got=%h/%h/%b exp=ff/7f/1", anode, cathode, wr_ready);
        end
        reset = 1'b0;
        ticks(FRAME + 4);
        check_digit(0, 7'h7F);
        check_digit(4, 7'h7F);

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 1200; i++) begin
            wr_valid  = ($urandom_range(0, 3) == 0);
            wr_digit  = 3'($urandom_range(0, 7));
            wr_value  = 5'($urandom_range(0, 31));
            wr_commit = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 50) == 0) record = ~record;
            if ($urandom_range(0, 50) == 0) play = ~play;
            if ($urandom_range(0, 30) == 0) recordNum = ~recordNum;
            if ($urandom_range(0, 30) == 0) clipPlayNum = ~clipPlayNum;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
